instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit for the RV32 subset core. Consumes the next-PC value produced by the core's PC control logic through a redirect port, and otherwise advances sequentially. Issues word reads to instruction memory over a request/response handshake and presents each fetched instruction, with its PC, to decode through a one-entry valid/ready output buffer. Sits between the PC control path and the decode stage.

## Interface
- WIDTH, 32, address/PC width in bits
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clock  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- redirect  input  1  load redirect_pc as next fetch PC this cycle
- redirect_pc  input  WIDTH  target PC; bits [1:0] ignored (treated as 0)
- imem_req  output  1  read request valid
- imem_addr  output  WIDTH  word-aligned read address
- imem_ready  input  1  memory accepts request when imem_req && imem_ready
- imem_rvalid  input  1  read data valid (one response per accepted request, ≥1 cycle later)
- imem_rdata  input  32  read data
- instr_valid  output  1  instr/instr_pc hold a fetched instruction
- instr  output  32  instruction word
- instr_pc  output  WIDTH  PC of instr
- instr_ready  input  1  decode consumes when instr_valid && instr_ready

## Operation
- States: REQ, WAIT, DRAIN.
- REQ: imem_req = !reset && !redirect && (!instr_valid || instr_ready); imem_addr = pc. Accept (req && imem_ready) → WAIT, pc_inflight <= pc.
- WAIT: imem_rvalid → buffer loads {imem_rdata, pc_inflight}, instr_valid <= 1, pc <= pc_inflight + 4, → REQ.
- DRAIN: one response outstanding but stale; imem_rvalid → discard, → REQ. No new request issued in DRAIN.
- Redirect (any state, highest priority below reset): pc <= {redirect_pc[WIDTH-1:2], 2'b00}; instr_valid <= 0 (buffered instruction dropped even if instr_ready same cycle); state: WAIT without rvalid → DRAIN; WAIT with rvalid same cycle → REQ (response discarded); REQ/DRAIN → REQ (DRAIN with rvalid → REQ, without → DRAIN).
- Buffer consume: instr_valid && instr_ready && no load/redirect → instr_valid <= 0. Load and consume same cycle → buffer holds new entry.
- At most one outstanding memory request at any time.
- PC arithmetic modulo 2^WIDTH: 0xFFFF_FFFC + 4 → 0x0000_0000, no flag.
- Unexpected imem_rvalid in REQ: ignored.

## Timing
- Reset (synchronous): state = REQ, pc = RESET_PC, instr_valid = 0, instr = 0, instr_pc = 0; imem_req = 0 while reset high; imem_addr = pc.
- First imem_req high the cycle after reset deasserts.
- Latency: request accepted cycle N, rvalid cycle N+1 → instr_valid high cycle N+2, next imem_req also cycle N+2.
- Peak throughput: one instruction per 2 cycles (single outstanding request).
- Redirect at cycle N: imem_addr = redirect target from cycle N+1 (or after drain); instr_valid low at N+1.
- Reset mid-WAIT: pending response forgotten; an rvalid arriving after reset in REQ is ignored.
- imem_req/imem_addr stable until accepted unless redirect or reset intervenes (redirect may withdraw a request).

## Structure
- Shared package `ifetch_pkg`: state enum (REQ, WAIT, DRAIN), INSTR_BYTES = 4, NOP word 32'h0000_0013 for bench use.
- One sub-module natural: `fetch_buffer` — one-entry valid/ready holding register for {instr, instr_pc} with load, consume, flush inputs.
- FSM, pc and pc_inflight registers in top level.

## Test plan
- Reset release, imem_ready=1, rvalid 1 cycle after accept, rdata=0x00500093, instr_ready=1 → imem_addr 0x0, instr_valid cycle N+2 with instr 0x00500093, instr_pc 0x0; next imem_addr 0x4.
- instr_ready=0 for 5 cycles after first fetch → instr held stable, imem_req stays 0 until consumed, then fetch of 0x4.
- Redirect to 0x103 during WAIT (rvalid 2 cycles later) → stale response discarded, instr_valid stays 0, next imem_addr 0x100, following instr_pc 0x100.
- Redirect same cycle as rvalid and as instr_ready with valid buffer → both entries dropped, next imem_addr = target.
- pc at 0xFFFF_FFFC fetch → next imem_addr 0x0000_0000.
- Reset asserted while in WAIT, rvalid arrives cycle after reset release → ignored; imem_addr RESET_PC, instr_valid 0 until genuine response.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch unit.
//   fetch_state_e : fetch FSM states (REQ, WAIT, DRAIN)
//   INSTR_BYTES   : byte stride between sequential instructions
//   INSTR_W       : instruction word width
//   NOP_WORD      : canonical RV32 NOP (addi x0, x0, 0), used as filler data
package ifetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned INSTR_W     = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0013;

    // REQ: may issue a read; WAIT: live response pending; DRAIN: stale response pending
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: one-entry valid/ready holding register for {instr, pc}.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   load_i         : capture load_instr_i / load_pc_i, entry becomes valid
//   load_instr_i   : instruction word to capture
//   load_pc_i      : PC of the instruction to capture
//   consume_i      : downstream ready; clears a valid entry unless loading
//   flush_i        : drop the entry (wins over load and consume)
//   valid_o        : entry holds a fetched instruction
//   instr_o, pc_o  : held instruction word and its PC
module fetch_buffer
    import ifetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_i,
    input  logic [INSTR_W-1:0] load_instr_i,
    input  logic [WIDTH-1:0]   load_pc_i,
    input  logic               consume_i,
    input  logic               flush_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [WIDTH-1:0]   pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [WIDTH-1:0]   pc_q,    pc_d;

    // Next entry: flush beats load, load beats consume (load+consume keeps the new entry)
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = load_instr_i;
            pc_d    = load_pc_i;
        end else if (consume_i && valid_q) begin
            valid_d = 1'b0;
        end
    end

    // Entry registers
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetch with redirect, one outstanding
// word read to instruction memory, and a one-entry output buffer to decode.
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   redirect/redirect_pc : load a new fetch PC (low two bits ignored)
//   imem_req/imem_addr   : read request and word-aligned address
//   imem_ready           : memory accepts when imem_req && imem_ready
//   imem_rvalid/rdata    : read response, one per accepted request
//   instr_valid/instr/instr_pc : fetched instruction presented to decode
//   instr_ready          : decode consumes when instr_valid && instr_ready
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int unsigned     WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               redirect,
    input  logic [WIDTH-1:0]   redirect_pc,
    output logic               imem_req,
    output logic [WIDTH-1:0]   imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [WIDTH-1:0]   instr_pc,
    input  logic               instr_ready
);

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(INSTR_BYTES);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_inflight_q, pc_inflight_d;
    logic [WIDTH-1:0] redirect_target;
    logic             buf_load;
    logic             unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc[WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Next-state, pc update, request and buffer-load control
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_inflight_d = pc_inflight_q;
        buf_load      = 1'b0;

        // Only request when the buffer can take the result (empty or draining now)
        imem_req = (state_q == REQ) && !reset && !redirect
                   && (!instr_valid || instr_ready);

        unique case (state_q)
            REQ: begin
                // Stray rvalid here is ignored by construction
                if (imem_req && imem_ready) begin
                    state_d       = WAIT;
                    pc_inflight_d = pc_q;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    buf_load = 1'b1;
                    pc_d     = pc_inflight_q + PC_STEP;
                    state_d  = REQ;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase

        // Redirect discards any response landing this cycle and any pending one
        if (redirect) begin
            buf_load = 1'b0;
            pc_d     = redirect_target;
            if (state_q == WAIT && !imem_rvalid) begin
                state_d = DRAIN;
            end
        end
    end

    // State, fetch PC and in-flight PC registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= REQ;
            pc_q          <= RESET_PC;
            pc_inflight_q <= RESET_PC;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_inflight_q <= pc_inflight_d;
        end
    end

    assign imem_addr = pc_q;

    fetch_buffer #(
        .WIDTH (WIDTH)
    ) u_fetch_buffer (
        .clock        (clock),
        .reset        (reset),
        .load_i       (buf_load),
        .load_instr_i (imem_rdata),
        .load_pc_i    (pc_inflight_q),
        .consume_i    (instr_ready),
        .flush_i      (redirect),
        .valid_o      (instr_valid),
        .instr_o      (instr),
        .pc_o         (instr_pc)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by randomized traffic.
// A program-order model (expected {pc, instr} stream) feeds a scoreboard that
// a monitor pops on every decode consumption; a memory responder models imem.
module tb_instr_fetch;
    import ifetch_pkg::*;

    localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int errors = 0;
    int checks = 0;
    int consumed = 0;

    exp_t        exp_q[$];
    logic [31:0] model_pc;

    // responder knobs
    int lat_lo = 1, lat_hi = 1, ready_pct = 100, spur_pct = 0;

    always #5 clock = ~clock;

    instr_fetch #(
        .WIDTH    (32),
        .RESET_PC (RESET_PC_TB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    // Instruction memory contents
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[31:2] ^ 30'h2A5C_3F1D, 2'b11};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        model_pc = RESET_PC_TB;
    endfunction

    function automatic void model_redirect(input logic [31:0] t);
        exp_q.delete();
        model_pc = {t[31:2], 2'b00};
    endfunction

    // Program order: sequential words from the current stream start, wrapping mod 2^32
    function automatic void refill();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.pc    = model_pc;
            e.instr = mem_word(model_pc);
            exp_q.push_back(e);
            model_pc = model_pc + 32'd4;
        end
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
        refill();
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    // Memory responder: one response per accept after lat_lo..lat_hi cycles
    bit          busy = 1'b0;
    bit          orphan = 1'b0;
    int          lat_cnt = 0;
    logic [31:0] pend_addr = '0;

    initial begin
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clock);
            if (reset && busy) orphan = 1'b1;
            if (busy && !orphan) check("req_while_outstanding", 32'(imem_req), 32'd0);
            if (imem_req && imem_ready) begin
                check("addr_align", 32'(imem_addr[1:0]), 32'd0);
                busy      = 1'b1;
                orphan    = 1'b0;
                pend_addr = imem_addr;
                lat_cnt   = $urandom_range(lat_hi, lat_lo);
            end
            @(posedge clock);
            #1;
            imem_rvalid = 1'b0;
            if (busy) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = orphan ? NOP_WORD : mem_word(pend_addr);
                    busy        = 1'b0;
                end
            end else if ($urandom_range(99, 0) < spur_pct) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
            end
            imem_ready = !busy && ($urandom_range(99, 0) < ready_pct);
        end
    end

    // Monitor: scoreboard pop on consumption, plus hold and redirect-drop rules
    initial begin
        exp_t        e;
        bit          prev_redirect = 1'b0;
        bit          hold_pend = 1'b0;
        logic [31:0] hold_pc = '0;
        logic [31:0] hold_instr = '0;
        forever begin
            @(negedge clock);
            if (prev_redirect) check("valid_after_redirect", 32'(instr_valid), 32'd0);
            if (hold_pend) begin
                check("hold_valid", 32'(instr_valid), 32'd1);
                check("hold_pc", instr_pc, hold_pc);
                check("hold_instr", instr, hold_instr);
            end
            prev_redirect = 1'b0;
            hold_pend     = 1'b0;
            if (!reset) begin
                if (redirect) check("req_during_redirect", 32'(imem_req), 32'd0);
                if (instr_valid && instr_ready && !redirect) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty: consumed pc %08h with no expected entry", instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_pc", instr_pc, e.pc);
                        check("sb_instr", instr, e.instr);
                        consumed++;
                    end
                end
                if (instr_valid && !instr_ready && !redirect) begin
                    hold_pend  = 1'b1;
                    hold_pc    = instr_pc;
                    hold_instr = instr;
                end
                prev_redirect = redirect;
            end
        end
    end

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Driver: directed scenarios then randomized traffic
    initial begin
        int rst_left;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        model_reset();

        repeat (3) begin
            next_cycle();
            mid();
            check("rst_req", 32'(imem_req), 32'd0);
            check("rst_valid", 32'(instr_valid), 32'd0);
            check("rst_instr", instr, 32'd0);
            check("rst_instr_pc", instr_pc, 32'd0);
            check("rst_addr", imem_addr, RESET_PC_TB);
        end

        // First fetch latency
        next_cycle(); reset = 1'b0; model_reset(); refill();
        mid(); check("c1_req", 32'(imem_req), 32'd1); check("c1_addr", imem_addr, 32'h0);
        check("c1_valid", 32'(instr_valid), 32'd0);
        next_cycle(); mid(); check("c2_req", 32'(imem_req), 32'd0);
        check("c2_valid", 32'(instr_valid), 32'd0);
        next_cycle(); mid();
        check("c3_valid", 32'(instr_valid), 32'd1);
        check("c3_instr", instr, 32'h0050_0093);
        check("c3_pc", instr_pc, 32'h0);
        check("c3_req", 32'(imem_req), 32'd1);
        check("c3_addr", imem_addr, 32'h4);
        next_cycle(); mid(); check("c4_req", 32'(imem_req), 32'd0);

        // Decode stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            next_cycle(); instr_ready = 1'b0;
            mid();
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_pc", instr_pc, 32'h4);
            check("stall_instr", instr, mem_word(32'h4));
            check("stall_req", 32'(imem_req), 32'd0);
        end
        next_cycle(); instr_ready = 1'b1; lat_lo = 3; lat_hi = 3;
        mid(); check("unstall_req", 32'(imem_req), 32'd1); check("unstall_addr", imem_addr, 32'h8);

        // Redirect during WAIT, stale response two cycles later
        next_cycle(); redirect = 1'b1; redirect_pc = 32'h103; model_redirect(redirect_pc); refill();
        mid(); check("rd_wait_req", 32'(imem_req), 32'd0);
        next_cycle(); redirect = 1'b0; lat_lo = 1; lat_hi = 1;
        mid(); check("drain_valid", 32'(instr_valid), 32'd0); check("drain_req", 32'(imem_req), 32'd0);
        next_cycle(); mid();
        check("drain_rsp_valid", 32'(instr_valid), 32'd0); check("drain_rsp_req", 32'(imem_req), 32'd0);
        next_cycle(); mid();
        check("post_drain_req", 32'(imem_req), 32'd1); check("post_drain_addr", imem_addr, 32'h100);
        check("post_drain_valid", 32'(instr_valid), 32'd0);
        next_cycle(); mid(); check("c15_req", 32'(imem_req), 32'd0);

        // Redirect in REQ with a valid buffer and decode ready: entry dropped
        next_cycle(); redirect = 1'b1; redirect_pc = 32'h200; model_redirect(redirect_pc); refill();
        mid();
        check("tgt_valid", 32'(instr_valid), 32'd1);
        check("tgt_pc", instr_pc, 32'h100);
        check("tgt_instr", instr, mem_word(32'h100));
        next_cycle(); redirect = 1'b0;
        mid();
        check("flush_valid", 32'(instr_valid), 32'd0);
        check("flush_req", 32'(imem_req), 32'd1);
        check("flush_addr", imem_addr, 32'h200);

        // Redirect in the same cycle as the response, target near the top of memory
        next_cycle(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; model_redirect(redirect_pc); refill();
        mid(); check("rd_rsp_req", 32'(imem_req), 32'd0);
        next_cycle(); redirect = 1'b0;
        mid();
        check("rd_rsp_valid", 32'(instr_valid), 32'd0);
        check("rd_rsp_req2", 32'(imem_req), 32'd1);
        check("rd_rsp_addr", imem_addr, 32'hFFFF_FFFC);
        next_cycle(); mid(); check("wrap_wait_valid", 32'(instr_valid), 32'd0);
        next_cycle(); lat_lo = 3; lat_hi = 3;
        mid();
        check("wrap_valid", 32'(instr_valid), 32'd1);
        check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_req", 32'(imem_req), 32'd1);
        check("wrap_addr", imem_addr, 32'h0);

        // Reset while WAIT; the old response arrives after release and is ignored
        next_cycle(); reset = 1'b1; model_reset(); refill();
        mid();
        next_cycle(); reset = 1'b0; lat_lo = 1; lat_hi = 1;
        mid();
        check("rw_req", 32'(imem_req), 32'd1); check("rw_addr", imem_addr, RESET_PC_TB);
        check("rw_valid", 32'(instr_valid), 32'd0);
        next_cycle(); mid();
        check("rw_orphan_valid", 32'(instr_valid), 32'd0); check("rw_orphan_addr", imem_addr, RESET_PC_TB);
        next_cycle(); mid(); check("rw_ignored_valid", 32'(instr_valid), 32'd0);
        next_cycle(); mid();
        check("rw_real_valid", 32'(instr_valid), 32'd1);
        check("rw_real_instr", instr, 32'h0050_0093);
        check("rw_real_pc", instr_pc, RESET_PC_TB);

        // Randomized traffic
        lat_lo = 1; lat_hi = 3; ready_pct = 70; spur_pct = 10;
        rst_left = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            next_cycle();
            redirect = 1'b0;
            if (rst_left > 0) begin
                reset = 1'b1;
                rst_left--;
                model_reset();
            end else begin
                reset = 1'b0;
                if ($urandom_range(199, 0) == 0) begin
                    reset    = 1'b1;
                    rst_left = $urandom_range(1, 0);
                    model_reset();
                end else if ($urandom_range(99, 0) < 5) begin
                    redirect = 1'b1;
                    case ($urandom_range(3, 0))
                        0:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
                        1:       redirect_pc = 32'($urandom_range(255, 0));
                        default: redirect_pc = $urandom;
                    endcase
                    model_redirect(redirect_pc);
                end
            end
            instr_ready = ($urandom_range(99, 0) < 70);
            refill();
        end

        next_cycle();
        reset = 1'b0; redirect = 1'b0; instr_ready = 1'b1;
        repeat (10) next_cycle();
        mid();
        check("progress", 32'(consumed >= 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
